// File: rtl/prbs_pkg.sv
// prbs_pkg
//   Shared definitions for the PRBS checker and its matching pattern generator.
//   - prbs_state_t : checker FSM states (SEED while acquiring, LOCKED while checking)
//   - PRBS8_TAPS   : default feedback mask for N=8, x^8+x^6+x^5+x^4+1
//   - lfsr_fb()    : XOR-reduced feedback bit of a Fibonacci LFSR state
package prbs_pkg;

  typedef enum logic {
    SEED   = 1'b0,
    LOCKED = 1'b1
  } prbs_state_t;

  localparam logic [7:0] PRBS8_TAPS = 8'b1011_1000;

  // Widest LFSR the feedback helper accepts; narrower states are zero-extended.
  localparam int LFSR_MAX_W = 32;

  // Feedback bit: parity of the tapped state bits.
  function automatic logic lfsr_fb(input logic [LFSR_MAX_W-1:0] state,
                                   input logic [LFSR_MAX_W-1:0] taps);
    return ^(state & taps);
  endfunction

endpackage

// File: rtl/prbs_checker_if.sv
// prbs_checker_if
//   Bundles the serial input stream, the clear request and the checker status.
//   Ports (seen from the checker / slave side):
//     in_valid, in_bit : received serial bit and its qualifier
//     clr              : synchronous clear of the error counter
//     locked           : checker is synchronised to the stream
//     err_pulse        : one-cycle pulse, previous accepted bit mismatched
//     lock_lost        : one-cycle pulse, lock has just been dropped
//     err_count        : saturating mismatch count, CW bits
interface prbs_checker_if #(
  parameter int CW = 16
) ();

  logic          in_valid;
  logic          in_bit;
  logic          clr;
  logic          locked;
  logic          err_pulse;
  logic          lock_lost;
  logic [CW-1:0] err_count;

  // The stream source drives data and clear and observes the status.
  modport master (
    output in_valid, in_bit, clr,
    input  locked, err_pulse, lock_lost, err_count
  );

  // The checker consumes data and clear and drives the status.
  modport slave (
    input  in_valid, in_bit, clr,
    output locked, err_pulse, lock_lost, err_count
  );

endinterface

// File: rtl/prbs_checker_lfsr_step.sv
// lfsr_step
//   Combinational single step of an N-bit Fibonacci LFSR. Shared by the
//   checker and the generator so both ends advance bit-exactly.
//   Ports:
//     state      : current LFSR state
//     state_next : {state[N-2:0], fb}
//     fb         : feedback bit (also the generator's serial output bit)
module lfsr_step
  import prbs_pkg::*;
#(
  parameter int             N    = 8,
  parameter logic [N-1:0]   TAPS = PRBS8_TAPS
) (
  input  logic [N-1:0] state,
  output logic [N-1:0] state_next,
  output logic         fb
);

  // Zero-extend into the helper's fixed width; unused high taps are zero.
  assign fb         = lfsr_fb(LFSR_MAX_W'(state), LFSR_MAX_W'(TAPS));
  assign state_next = {state[N-2:0], fb};

endmodule

// File: rtl/prbs_checker.sv
// prbs_checker
//   Receive-side PRBS checker. Seeds its LFSR directly from N received bits,
//   then predicts every further bit and counts mismatches. Too many errors
//   inside one WIN-bit window drops lock and re-seeds from the stream.
//   Ports:
//     clk  : clock, rising edge
//     rst  : asynchronous reset, active low
//     bus  : prbs_checker_if slave modport (stream in, status out)
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int           N          = 8,
  parameter logic [N-1:0] TAPS       = PRBS8_TAPS,
  parameter int           WIN        = 64,
  parameter int           ERR_THRESH = 4,
  parameter int           CW         = 16
) (
  input  logic           clk,
  input  logic           rst,
  prbs_checker_if.slave  bus
);

  localparam int SW = $clog2(N + 1);
  localparam int WW = $clog2(WIN + 1);

  localparam logic [SW-1:0] SEED_LAST = SW'(N - 1);
  localparam logic [WW-1:0] WIN_END   = WW'(WIN);
  localparam logic [WW-1:0] THRESH    = WW'(ERR_THRESH);
  localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};

  prbs_state_t   fsm_q, fsm_d;
  logic [N-1:0]  state_q, state_d;
  logic [SW-1:0] seed_cnt_q, seed_cnt_d;
  logic [WW-1:0] win_cnt_q, win_cnt_d;
  logic [WW-1:0] win_err_q, win_err_d;
  logic          locked_q, locked_d;
  logic          err_pulse_q, err_pulse_d;
  logic          lock_lost_q, lock_lost_d;
  logic [CW-1:0] err_count_q, err_count_d;

  logic [N-1:0]  pred_state;
  logic          pred;
  logic [N-1:0]  seed_shift;
  logic          mismatch;
  logic [WW-1:0] win_cnt_inc;
  logic [WW-1:0] win_err_inc;

  // Predicted next state and bit, identical to what the generator computes.
  lfsr_step #(
    .N    (N),
    .TAPS (TAPS)
  ) u_step (
    .state      (state_q),
    .state_next (pred_state),
    .fb         (pred)
  );

  // State register for the FSM, LFSR, window counters and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_q       <= SEED;
      state_q     <= '0;
      seed_cnt_q  <= '0;
      win_cnt_q   <= '0;
      win_err_q   <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      lock_lost_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      fsm_q       <= fsm_d;
      state_q     <= state_d;
      seed_cnt_q  <= seed_cnt_d;
      win_cnt_q   <= win_cnt_d;
      win_err_q   <= win_err_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
      lock_lost_q <= lock_lost_d;
      err_count_q <= err_count_d;
    end
  end

  // Next-state logic. In SEED the received bit is shifted in; in LOCKED the
  // predicted bit is shifted in so a line error never corrupts the state.
  // Threshold is evaluated before the window wrap, so a hit on the last
  // window bit still drops lock. clr overrides any increment that cycle.
  always_comb begin
    fsm_d       = fsm_q;
    state_d     = state_q;
    seed_cnt_d  = seed_cnt_q;
    win_cnt_d   = win_cnt_q;
    win_err_d   = win_err_q;
    locked_d    = locked_q;
    err_pulse_d = 1'b0;
    lock_lost_d = 1'b0;
    err_count_d = err_count_q;
    seed_shift  = {state_q[N-2:0], bus.in_bit};
    mismatch    = 1'b0;
    win_cnt_inc = win_cnt_q + WW'(1);
    win_err_inc = win_err_q;

    if (bus.in_valid) begin
      unique case (fsm_q)
        SEED: begin
          state_d = seed_shift;
          if (seed_cnt_q == SEED_LAST) begin
            seed_cnt_d = '0;
            if (seed_shift != '0) begin
              fsm_d     = LOCKED;
              locked_d  = 1'b1;
              win_cnt_d = '0;
              win_err_d = '0;
            end
          end else begin
            seed_cnt_d = seed_cnt_q + SW'(1);
          end
        end
        LOCKED: begin
          state_d     = pred_state;
          mismatch    = bus.in_bit ^ pred;
          win_err_inc = win_err_q + WW'(mismatch);
          if (mismatch) begin
            err_pulse_d = 1'b1;
            if (err_count_q != CNT_MAX) begin
              err_count_d = err_count_q + CW'(1);
            end
          end
          if (win_err_inc == THRESH) begin
            fsm_d       = SEED;
            locked_d    = 1'b0;
            lock_lost_d = 1'b1;
            seed_cnt_d  = '0;
            win_cnt_d   = '0;
            win_err_d   = '0;
          end else if (win_cnt_inc == WIN_END) begin
            win_cnt_d = '0;
            win_err_d = '0;
          end else begin
            win_cnt_d = win_cnt_inc;
            win_err_d = win_err_inc;
          end
        end
        default: begin
          fsm_d = SEED;
        end
      endcase
    end

    if (bus.clr) begin
      err_count_d = '0;
    end
  end

  assign bus.locked    = locked_q;
  assign bus.err_pulse = err_pulse_q;
  assign bus.lock_lost = lock_lost_q;
  assign bus.err_count = err_count_q;

endmodule

// File: tb/tb_prbs_checker.sv
// tb_prbs_checker
//   Directed self-checking bench for prbs_checker (N=8, WIN=64, ERR_THRESH=4,
//   CW=4). A local reference generator produces the stream; selected bits are
//   inverted to inject errors, and expected status values are fixed constants.
module tb_prbs_checker;

  localparam int         N          = 8;
  localparam int         WIN        = 64;
  localparam int         ERR_THRESH = 4;
  localparam int         CW         = 4;
  localparam logic [7:0] GEN_TAPS   = 8'b1011_1000;

  logic clk = 1'b0;
  logic rst;

  prbs_checker_if #(.CW(CW)) bus ();

  prbs_checker #(
    .N          (N),
    .TAPS       (GEN_TAPS),
    .WIN        (WIN),
    .ERR_THRESH (ERR_THRESH),
    .CW         (CW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  int         testsRun    = 0;
  int         testsFailed = 0;
  int         pulseSeen   = 0;
  int         lostSeen    = 0;
  int         accepted    = 0;
  logic [7:0] genState;

  // Single comparison point: counts every check, reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Drive one cycle of input, then sample #1 after the rising edge.
  task automatic applyStimulus(input logic v, input logic b);
    bus.in_valid = v;
    bus.in_bit   = b;
    @(posedge clk);
    #1;
    pulseSeen += int'(bus.err_pulse);
    lostSeen  += int'(bus.lock_lost);
  endtask

  // Advance the reference generator and send its bit, optionally inverted.
  task automatic sendGen(input logic flip);
    logic fb;
    fb       = ^(genState & GEN_TAPS);
    genState = {genState[6:0], fb};
    applyStimulus(1'b1, fb ^ flip);
  endtask

  task automatic clearTallies();
    pulseSeen = 0;
    lostSeen  = 0;
  endtask

  // Hard stop if the sequence ever stalls.
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main directed sequence.
  initial begin
    logic v;
    logic flip;
    rst          = 1'b0;
    bus.clr      = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_bit   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_locked",    32'(bus.locked),    32'd0);
    checkOutput("rst_err_pulse", 32'(bus.err_pulse), 32'd0);
    checkOutput("rst_lock_lost", 32'(bus.lock_lost), 32'd0);
    checkOutput("rst_err_count", 32'(bus.err_count), 32'd0);
    rst = 1'b1;

    // Clean lock from seed A5, then 1000 clean bits in total.
    genState = 8'hA5;
    clearTallies();
    repeat (7) sendGen(1'b0);
    checkOutput("clean_unlocked_7", 32'(bus.locked), 32'd0);
    sendGen(1'b0);
    checkOutput("clean_locked_8", 32'(bus.locked), 32'd1);
    repeat (992) sendGen(1'b0);
    checkOutput("clean_pulses",    32'(pulseSeen),     32'd0);
    checkOutput("clean_lost",      32'(lostSeen),      32'd0);
    checkOutput("clean_err_count", 32'(bus.err_count), 32'd0);
    checkOutput("clean_locked",    32'(bus.locked),    32'd1);

    // One inverted bit: one pulse, no error multiplication afterwards.
    clearTallies();
    sendGen(1'b1);
    checkOutput("single_pulse",     32'(bus.err_pulse), 32'd1);
    checkOutput("single_err_count", 32'(bus.err_count), 32'd1);
    checkOutput("single_locked",    32'(bus.locked),    32'd1);
    repeat (100) sendGen(1'b0);
    checkOutput("single_pulses_total", 32'(pulseSeen),     32'd1);
    checkOutput("single_err_after",    32'(bus.err_count), 32'd1);

    // clr on an idle cycle zeroes the count and leaves lock alone.
    bus.clr = 1'b1;
    applyStimulus(1'b0, 1'b0);
    bus.clr = 1'b0;
    checkOutput("clr_err_count", 32'(bus.err_count), 32'd0);
    checkOutput("clr_locked",    32'(bus.locked),    32'd1);

    // Four errors inside one window drop lock on the fourth.
    clearTallies();
    for (int k = 0; k < 3; k++) begin
      sendGen(1'b1);
      sendGen(1'b0);
    end
    checkOutput("lol_locked_3",    32'(bus.locked),    32'd1);
    checkOutput("lol_lost_3",      32'(lostSeen),      32'd0);
    checkOutput("lol_err_count_3", 32'(bus.err_count), 32'd3);
    sendGen(1'b1);
    checkOutput("lol_lock_lost", 32'(bus.lock_lost), 32'd1);
    checkOutput("lol_locked",    32'(bus.locked),    32'd0);
    checkOutput("lol_err_pulse", 32'(bus.err_pulse), 32'd1);
    checkOutput("lol_err_count", 32'(bus.err_count), 32'd4);

    // Re-lock after exactly 8 clean bits.
    sendGen(1'b0);
    checkOutput("relock_lost_pulse_end", 32'(bus.lock_lost), 32'd0);
    repeat (6) sendGen(1'b0);
    checkOutput("relock_unlocked_7", 32'(bus.locked), 32'd0);
    sendGen(1'b0);
    checkOutput("relock_locked_8", 32'(bus.locked), 32'd1);

    // Three errors per window for five windows, including the last window bit.
    bus.clr = 1'b1;
    applyStimulus(1'b0, 1'b0);
    bus.clr = 1'b0;
    clearTallies();
    for (int w = 0; w < 5; w++) begin
      for (int i = 0; i < WIN; i++) begin
        sendGen(i == 1 || i == 30 || i == 63);
      end
    end
    checkOutput("win3_err_count", 32'(bus.err_count), 32'd15);
    checkOutput("win3_pulses",    32'(pulseSeen),     32'd15);
    checkOutput("win3_lost",      32'(lostSeen),      32'd0);
    checkOutput("win3_locked",    32'(bus.locked),    32'd1);

    // Saturation at 2^CW-1, then clr beats a simultaneous mismatch.
    sendGen(1'b1);
    checkOutput("sat_pulse",     32'(bus.err_pulse), 32'd1);
    checkOutput("sat_err_count", 32'(bus.err_count), 32'd15);
    bus.clr = 1'b1;
    sendGen(1'b1);
    bus.clr = 1'b0;
    checkOutput("clr_mis_pulse", 32'(bus.err_pulse), 32'd1);
    checkOutput("clr_mis_count", 32'(bus.err_count), 32'd0);
    sendGen(1'b1);
    checkOutput("post_clr_count",  32'(bus.err_count), 32'd1);
    checkOutput("post_clr_locked", 32'(bus.locked),    32'd1);

    // Asynchronous reset mid-lock, checked before the next clock edge.
    bus.in_valid = 1'b0;
    #3;
    rst = 1'b0;
    #1;
    checkOutput("async_locked",    32'(bus.locked),    32'd0);
    checkOutput("async_err_count", 32'(bus.err_count), 32'd0);
    checkOutput("async_err_pulse", 32'(bus.err_pulse), 32'd0);
    checkOutput("async_lock_lost", 32'(bus.lock_lost), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // All-zero seed is refused; the following generator bits lock.
    repeat (8) applyStimulus(1'b1, 1'b0);
    checkOutput("zero_seed_unlocked", 32'(bus.locked), 32'd0);
    genState = 8'h3C;
    repeat (7) sendGen(1'b0);
    checkOutput("zero_then_unlocked_7", 32'(bus.locked), 32'd0);
    sendGen(1'b0);
    checkOutput("zero_then_locked_8", 32'(bus.locked), 32'd1);
    clearTallies();
    repeat (50) sendGen(1'b0);
    checkOutput("zero_then_pulses",    32'(pulseSeen),     32'd0);
    checkOutput("zero_then_err_count", 32'(bus.err_count), 32'd0);

    // Pseudo-random in_valid gaps from a fresh reset; one error on accepted bit 21.
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst      = 1'b1;
    genState = 8'h5A;
    accepted = 0;
    for (int c = 0; c < 300; c++) begin
      v    = 1'($urandom_range(0, 1));
      flip = v && (accepted == 20);
      if (v) begin
        sendGen(flip);
        accepted++;
      end else begin
        applyStimulus(1'b0, 1'($urandom_range(0, 1)));
      end
      checkOutput("gap_locked",    32'(bus.locked),    32'(accepted >= N));
      checkOutput("gap_err_pulse", 32'(bus.err_pulse), 32'(flip));
      checkOutput("gap_lock_lost", 32'(bus.lock_lost), 32'd0);
    end
    checkOutput("gap_err_count", 32'(bus.err_count), 32'(accepted > 20));

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
